// File: rtl/item_memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : item_memory_arbiter_if
// Purpose  : Request/response bundle between requesters and the item-memory
//            arbiter. Carries NumReq request channels (valid/ready, CiM
//            select, A/B addresses) and one buffered response channel.
// Revision : 1.0 - initial release
// ============================================================================
interface item_memory_arbiter_if #(
    parameter int HVDimension = 512,
    parameter int NumTotIm    = 1024,
    parameter int NumReq      = 2
);
    localparam int ImSelWidth = $clog2(NumTotIm);
    localparam int IdWidth    = (NumReq > 1) ? $clog2(NumReq) : 1;

    // Request side: one lane per requester, addresses packed lane by lane
    logic [NumReq-1:0]            req_valid_i;
    logic [NumReq-1:0]            req_ready_o;
    logic [NumReq-1:0]            req_cim_i;
    logic [NumReq*ImSelWidth-1:0] req_addr_a_i;
    logic [NumReq*ImSelWidth-1:0] req_addr_b_i;

    // Response side: single registered entry tagged with requester index
    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [IdWidth-1:0]           rsp_id_o;
    logic [HVDimension-1:0]       rsp_hv_a_o;
    logic [HVDimension-1:0]       rsp_hv_b_o;

    // Requester / consumer view
    modport master (
        output req_valid_i, req_cim_i, req_addr_a_i, req_addr_b_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_hv_a_o, rsp_hv_b_o
    );

    // Arbiter view
    modport slave (
        input  req_valid_i, req_cim_i, req_addr_a_i, req_addr_b_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_hv_a_o, rsp_hv_b_o
    );
endinterface
`default_nettype wire

// File: rtl/item_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : item_memory_arbiter
// Purpose  : Round-robin arbiter sharing one item_memory between NumReq
//            requesters. The winner's addresses drive the item-memory ports
//            combinationally; both returned hypervectors are captured into a
//            one-entry response buffer tagged with the winner's index.
// Revision : 1.0 - initial release
// ============================================================================
module item_memory_arbiter #(
    parameter  int HVDimension = 512,
    parameter  int NumTotIm    = 1024,
    parameter  int NumReq      = 2,
    localparam int ImSelWidth  = $clog2(NumTotIm),
    localparam int IdWidth     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_ni,
    item_memory_arbiter_if.slave        bus,
    output logic                        port_a_cim_o,
    output logic [ImSelWidth-1:0]       im_a_addr_o,
    output logic [ImSelWidth-1:0]       im_b_addr_o,
    input  wire logic [HVDimension-1:0] im_a_i,
    input  wire logic [HVDimension-1:0] im_b_i
);

    // Response buffer state
    logic                   r_rsp_valid;
    logic [IdWidth-1:0]     r_rsp_id;
    logic [HVDimension-1:0] r_rsp_hv_a;
    logic [HVDimension-1:0] r_rsp_hv_b;

    // Round-robin priority pointer (first requester to be considered)
    logic [IdWidth-1:0]     r_ptr;

    // Arbitration results
    logic                   w_can_accept;
    logic                   w_found;
    logic [IdWidth-1:0]     w_winner;
    logic [IdWidth:0]       w_sum;
    logic [NumReq-1:0]      w_ready;
    logic                   w_handshake;

    // The buffer can take a new entry when empty or being drained this cycle
    assign w_can_accept = !r_rsp_valid || bus.rsp_ready_i;

    // Scan requesters starting at the pointer, wrapping modulo NumReq
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NumReq; k++) begin
            w_sum = {1'b0, r_ptr} + (IdWidth+1)'(k);
            if (w_sum >= (IdWidth+1)'(NumReq)) begin
                w_sum = w_sum - (IdWidth+1)'(NumReq);
            end
            if (!w_found && bus.req_valid_i[w_sum[IdWidth-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IdWidth-1:0];
            end
        end
    end

    // Steer the winner onto the item-memory ports; ready is gated by buffer space
    always_comb begin
        w_ready      = '0;
        port_a_cim_o = 1'b0;
        im_a_addr_o  = '0;
        im_b_addr_o  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_found && (w_winner == IdWidth'(i))) begin
                w_ready[i]   = w_can_accept;
                port_a_cim_o = bus.req_cim_i[i];
                im_a_addr_o  = bus.req_addr_a_i[i*ImSelWidth +: ImSelWidth];
                im_b_addr_o  = bus.req_addr_b_i[i*ImSelWidth +: ImSelWidth];
            end
        end
    end

    assign bus.req_ready_o = w_ready;
    assign w_handshake     = |(bus.req_valid_i & w_ready);

    generate
        if (NumReq > 1) begin : g_ptr_rr
            logic [IdWidth-1:0] w_ptr_next;

            // Next priority goes to the requester just after the winner
            always_comb begin
                w_ptr_next = (w_winner == IdWidth'(NumReq - 1)) ? '0
                                                                : w_winner + IdWidth'(1);
            end

            // Advance the pointer only when a request is actually accepted
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_ptr <= '0;
                end else if (w_handshake) begin
                    r_ptr <= w_ptr_next;
                end
            end
        end else begin : g_ptr_single
            assign r_ptr = '0;
        end
    endgenerate

    // Buffer occupancy: fill on handshake, empty on drain without refill
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
        end else if (w_handshake) begin
            r_rsp_valid <= 1'b1;
        end else if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Capture item-memory outputs and winner tag; held otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_id   <= '0;
            r_rsp_hv_a <= '0;
            r_rsp_hv_b <= '0;
        end else if (w_handshake) begin
            r_rsp_id   <= w_winner;
            r_rsp_hv_a <= im_a_i;
            r_rsp_hv_b <= im_b_i;
        end
    end

    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_id_o    = r_rsp_id;
    assign bus.rsp_hv_a_o  = r_rsp_hv_a;
    assign bus.rsp_hv_b_o  = r_rsp_hv_b;

endmodule
`default_nettype wire

// File: doc/item_memory_arbiter.md
# item_memory_arbiter

Round-robin arbiter and response buffer that shares one `item_memory` instance between `NumReq` requesters, e.g. the encoder datapath and the host readback path. Each requester issues an A/B address pair plus a CiM/iM select over a valid/ready handshake. The arbiter drives the granted request onto the item-memory address ports. It captures both combinational hypervector outputs into a one-entry registered response buffer, tagged with the requester ID. This block sits directly in front of `item_memory` in the encoder front end.

## Interface
- HVDimension, 512, hypervector width
- NumTotIm, 1024, total iM entries
- NumReq, 2, number of requesters (≥1)
- ImSelWidth, $clog2(NumTotIm), address width (derived, do not override)
- IdWidth, (NumReq>1) ? $clog2(NumReq) : 1, requester-ID width (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumReq  request valid per requester
- req_ready_o  out  NumReq  request accepted (one-hot grant)
- req_cim_i  in  NumReq  1 = port A reads CiM level, 0 = iM
- req_addr_a_i  in  NumReq×ImSelWidth  port A address (CiM level in low bits when req_cim_i=1)
- req_addr_b_i  in  NumReq×ImSelWidth  port B iM address
- rsp_valid_o  out  1  response buffer holds data
- rsp_ready_i  in  1  downstream accepts response
- rsp_id_o  out  IdWidth  requester index of buffered response
- rsp_hv_a_o  out  HVDimension  captured port A hypervector
- rsp_hv_b_o  out  HVDimension  captured port B hypervector
- port_a_cim_o  out  1  to item_memory port_a_cim_i
- im_a_addr_o  out  ImSelWidth  to item_memory im_a_addr_i
- im_b_addr_o  out  ImSelWidth  to item_memory im_b_addr_i
- im_a_i  in  HVDimension  from item_memory im_a_o
- im_b_i  in  HVDimension  from item_memory im_b_o

## Operation
- can_accept = !rsp_valid_o || rsp_ready_i, which allows a drain and a refill in the same cycle.
- Arbitration is combinational and round-robin. Search starts at priority pointer `ptr` and wraps modulo NumReq. The first requester with req_valid_i=1 wins.
- req_ready_o[i]=1 only for the winner, and only when can_accept. A handshake happens when req_valid_i[i] && req_ready_o[i]. At most one grant per cycle.
- Item-memory ports carry the winner's req_cim_i/addr_a/addr_b whenever a winner exists, even if can_accept=0; ready is still gated. With no valid request: port_a_cim_o=0, im_a_addr_o=0, im_b_addr_o=0.
- On handshake, at the next edge:
  - im_a_i → rsp_hv_a_o and im_b_i → rsp_hv_b_o
  - winner index → rsp_id_o
  - rsp_valid_o←1
  - ptr←(winner+1) mod NumReq
- Without a handshake, ptr holds.
- On rsp_valid_o && rsp_ready_i with no new handshake: rsp_valid_o←0. Data and ID registers hold their last value.
- While rsp_valid_o && !rsp_ready_i, all rsp_* outputs stay stable.
- Requesters keep valid, cim and addresses stable until ready. The arbiter does not check this.
- Addresses pass through unmodified. CiM-level truncation is done inside item_memory.
- NumReq=1 means ptr is constant 0 and rsp_id_o=0.

## Timing
- Reset (async assert, sync-safe deassert):
  - rsp_valid_o=0, rsp_id_o=0
  - rsp_hv_a_o=0, rsp_hv_b_o=0
  - ptr=0
  - req_ready_o is combinational, so it is all-zero only while no request is valid.
- Latency: handshake in cycle N means rsp_valid_o=1 in cycle N+1.
- Throughput: one response per cycle while rsp_ready_i=1.
- A reset asserted mid-transaction drops the buffered response immediately. The requester must re-issue after reset.
- A simultaneous drain and accept in cycle N keeps rsp_valid_o=1, with new data in N+1.
- The item-memory path is purely combinational within one cycle: arbiter → item_memory → capture register.

## Test plan
- Reset check: after rst_ni low then high, rsp_valid_o=0, rsp_id_o=0, both HV outputs zero, and port outputs zero with no request pending.
- Single request, NumReq=2: req 1 valid, cim=0, addr_a=5, addr_b=9 → req_ready_o=2'b10 in the same cycle. Next cycle rsp_valid_o=1, rsp_id_o=1, rsp_hv_a_o=iM[5], rsp_hv_b_o=iM[9].
- Fairness: both requesters continuously valid with rsp_ready_i=1 → grants alternate 0,1,0,1, and rsp_id_o follows one cycle later.
- Back-pressure: rsp_ready_i=0 for 4 cycles after the first response → req_ready_o=0 and rsp_* stable throughout. Raising rsp_ready_i gives a drain plus a new grant in the same cycle.
- CiM path: req 0 cim=1, addr_a=3, addr_b=7 → port_a_cim_o=1, im_a_addr_o=3. rsp_hv_a_o is CiM level 3 and rsp_hv_b_o=iM[7].
- Mid-operation reset: assert rst_ni while rsp_valid_o=1 and rsp_ready_i=0 → rsp_valid_o=0 asynchronously. After release, ptr=0, so requester 0 wins a simultaneous request.
